// File: rtl/counter_sched_if.sv
// Command and status bundle between a host/sequencer and the counter_sched timer.
// The host holds cmd_valid and cmd_op/cmd_* stable. A transfer occurs on the edge where cmd_valid && cmd_ready.
interface counter_sched_if #(
  parameter int CNT_W = 4,
  parameter int PRE_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_limit;
  logic [PRE_W-1:0] cmd_pre;
  logic             cmd_periodic;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       state;
  logic             tc;
  logic             cmd_err;

  modport master (
    output cmd_valid, cmd_op, cmd_limit, cmd_pre, cmd_periodic,
    input  cmd_ready, cnt, state, tc, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_limit, cmd_pre, cmd_periodic,
    output cmd_ready, cnt, state, tc, cmd_err
  );
endinterface

// File: rtl/counter_sched.sv
// Programmable timer controller: prescaled up-counter 0..limit with one-shot or periodic reload,
// commanded by start/pause/resume/abort. All outputs are registered.
module counter_sched #(
  parameter int CNT_W = 4,
  parameter int PRE_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  counter_sched_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_START  = 2'd0;
  localparam logic [1:0] OP_PAUSE  = 2'd1;
  localparam logic [1:0] OP_RESUME = 2'd2;
  localparam logic [1:0] OP_ABORT  = 2'd3;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             periodic_q, periodic_d;
  logic             tc_q, tc_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;

  logic accept;
  logic tick;
  logic cmd_taken;

  assign accept = bus.cmd_valid && ready_q;
  assign tick   = (state_q == S_RUN) && (pre_cnt_q == pre_q);

  // A legal command owns the edge and suppresses that cycle's tick.
  // An illegal command only raises cmd_err and leaves counting undisturbed.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    limit_d    = limit_q;
    pre_cnt_d  = pre_cnt_q;
    pre_d      = pre_q;
    periodic_d = periodic_q;
    tc_d       = 1'b0;
    err_d      = 1'b0;
    ready_d    = !accept;
    cmd_taken  = 1'b0;

    if (accept) begin
      case (bus.cmd_op)
        OP_START: begin
          if (state_q == S_IDLE || state_q == S_DONE) begin
            state_d    = S_RUN;
            limit_d    = bus.cmd_limit;
            pre_d      = bus.cmd_pre;
            periodic_d = bus.cmd_periodic;
            cnt_d      = '0;
            pre_cnt_d  = '0;
            cmd_taken  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        OP_PAUSE: begin
          if (state_q == S_RUN) begin
            state_d   = S_PAUSE;
            cmd_taken = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        OP_RESUME: begin
          if (state_q == S_PAUSE) begin
            state_d   = S_RUN;
            cmd_taken = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          pre_cnt_d = '0;
          cmd_taken = 1'b1;
        end
      endcase
    end

    if (!cmd_taken && state_q == S_RUN) begin
      if (tick) begin
        pre_cnt_d = '0;
        if (cnt_q == limit_q) begin
          tc_d = 1'b1;
          if (periodic_q) begin
            cnt_d = '0;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        pre_cnt_d = pre_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      limit_q    <= '0;
      pre_cnt_q  <= '0;
      pre_q      <= '0;
      periodic_q <= 1'b0;
      tc_q       <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      limit_q    <= limit_d;
      pre_cnt_q  <= pre_cnt_d;
      pre_q      <= pre_d;
      periodic_q <= periodic_d;
      tc_q       <= tc_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.cnt       = cnt_q;
  assign bus.state     = state_q;
  assign bus.tc        = tc_q;
  assign bus.cmd_err   = err_q;
  assign bus.cmd_ready = ready_q;

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: directed scenarios plus randomized commands, every cycle scored
// against a rule-level timer model through an expected-output queue.
module tb_counter_sched;
  localparam int CNT_W = 4;
  localparam int PRE_W = 8;
  localparam int EXP_W = CNT_W + 5;

  localparam logic [1:0] OP_START  = 2'd0;
  localparam logic [1:0] OP_PAUSE  = 2'd1;
  localparam logic [1:0] OP_RESUME = 2'd2;
  localparam logic [1:0] OP_ABORT  = 2'd3;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  counter_sched_if #(.CNT_W(CNT_W), .PRE_W(PRE_W)) bus ();

  counter_sched #(.CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  logic [EXP_W-1:0] exp_q[$];

  // reference timer state, kept as plain integers
  int m_mode, m_cnt, m_phase, m_limit, m_pre;
  bit m_periodic, m_tc, m_err, m_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_cnt = 0; m_phase = 0; m_limit = 0; m_pre = 0;
    m_periodic = 0; m_tc = 0; m_err = 0; m_ready = 1;
  endtask

  task automatic model_edge(input bit v, input logic [1:0] op, input int lim, input int pre, input bit per);
    bit acc, handled, tick, was_run;
    acc     = v && m_ready;
    was_run = (m_mode == M_RUN);
    tick    = was_run && (m_phase == m_pre);
    m_tc = 0; m_err = 0; m_ready = !acc; handled = 0;
    if (acc) begin
      if (op == OP_ABORT) begin
        m_mode = M_IDLE; m_cnt = 0; m_phase = 0; handled = 1;
      end else if (op == OP_START && (m_mode == M_IDLE || m_mode == M_DONE)) begin
        m_mode = M_RUN; m_limit = lim % (1 << CNT_W); m_pre = pre % (1 << PRE_W);
        m_periodic = per; m_cnt = 0; m_phase = 0; handled = 1;
      end else if (op == OP_PAUSE && m_mode == M_RUN) begin
        m_mode = M_PAUSE; handled = 1;
      end else if (op == OP_RESUME && m_mode == M_PAUSE) begin
        m_mode = M_RUN; handled = 1;
      end else begin
        m_err = 1;
      end
    end
    if (!handled && was_run) begin
      if (tick) begin
        m_phase = 0;
        if (m_cnt == m_limit) begin
          m_tc = 1;
          if (m_periodic) m_cnt = 0;
          else m_mode = M_DONE;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end else begin
        m_phase = m_phase + 1;
      end
    end
  endtask

  task automatic model_push();
    logic [1:0]       md;
    logic [CNT_W-1:0] c;
    md = m_mode[1:0];
    c  = m_cnt[CNT_W-1:0];
    exp_q.push_back({m_ready, m_err, m_tc, md, c});
  endtask

  task automatic compare_outputs();
    logic [EXP_W-1:0] e;
    if (exp_q.size() == 0) begin
      check("exp_queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("cnt",       32'(bus.cnt),       32'(e[CNT_W-1:0]));
      check("state",     32'(bus.state),     32'(e[CNT_W+1:CNT_W]));
      check("tc",        32'(bus.tc),        32'(e[CNT_W+2]));
      check("cmd_err",   32'(bus.cmd_err),   32'(e[CNT_W+3]));
      check("cmd_ready", 32'(bus.cmd_ready), 32'(e[CNT_W+4]));
    end
  endtask

  // driver: called just after a falling edge, returns just after the next one
  task automatic step(input bit v, input logic [1:0] op, input int lim, input int pre, input bit per);
    bus.cmd_valid    = v;
    bus.cmd_op       = op;
    bus.cmd_limit    = lim[CNT_W-1:0];
    bus.cmd_pre      = pre[PRE_W-1:0];
    bus.cmd_periodic = per;
    model_edge(v, op, lim, pre, per);
    model_push();
    @(posedge clk);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, OP_START, 0, 0, 1'b0);
  endtask

  task automatic cmd(input logic [1:0] op, input int lim, input int pre, input bit per);
    step(1'b1, op, lim, pre, per);
    idle(1);
  endtask

  task automatic async_reset_mid_cycle();
    #2;
    rst_n = 1'b0;
    model_reset();
    exp_q.delete();
    #1;
    check("async_rst_cnt",   32'(bus.cnt),       32'd0);
    check("async_rst_state", 32'(bus.state),     32'd0);
    check("async_rst_tc",    32'(bus.tc),        32'd0);
    check("async_rst_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    model_push();
    compare_outputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lim, pre, guard;
    bit v, per;
    logic [1:0] op;

    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = OP_START; bus.cmd_limit = '0;
    bus.cmd_pre = '0; bus.cmd_periodic = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_cnt",   32'(bus.cnt),       32'd0);
    check("reset_state", 32'(bus.state),     32'd0);
    check("reset_tc",    32'(bus.tc),        32'd0);
    check("reset_err",   32'(bus.cmd_err),   32'd0);
    check("reset_ready", 32'(bus.cmd_ready), 32'd1);
    rst_n = 1'b1;

    // one-shot, limit 3, tick every clock
    cmd(OP_START, 3, 0, 1'b0);
    idle(6);
    check("oneshot_done_state", 32'(bus.state), 32'd3);
    check("oneshot_done_cnt",   32'(bus.cnt),   32'd3);

    // periodic, limit 2, tick every 3 clocks
    cmd(OP_START, 2, 2, 1'b1);
    idle(22);
    check("periodic_state", 32'(bus.state), 32'd1);
    cmd(OP_ABORT, 0, 0, 1'b0);

    // pause at cnt 5 and resume with prescaler phase kept
    cmd(OP_START, 9, 1, 1'b0);
    guard = 0;
    while (m_cnt != 5 && guard < 40) begin
      idle(1);
      guard++;
    end
    check("reach_cnt5_in_budget", 32'(guard < 40), 32'd1);
    cmd(OP_PAUSE, 0, 0, 1'b0);
    idle(10);
    check("paused_state", 32'(bus.state), 32'd2);
    check("paused_cnt",   32'(bus.cnt),   32'd5);
    cmd(OP_RESUME, 0, 0, 1'b0);
    idle(12);

    // illegal commands
    cmd(OP_START, 9, 3, 1'b1);
    idle(3);
    cmd(OP_START, 1, 0, 1'b0);
    cmd(OP_ABORT, 0, 0, 1'b0);
    cmd(OP_RESUME, 0, 0, 1'b0);
    cmd(OP_PAUSE, 0, 0, 1'b0);

    // abort on the terminal tick: limit 1, pre 0
    step(1'b1, OP_START, 1, 0, 1'b0);
    idle(1);
    step(1'b1, OP_ABORT, 0, 0, 1'b0);
    check("abort_tc_tc",    32'(bus.tc),    32'd0);
    check("abort_tc_state", 32'(bus.state), 32'd0);
    check("abort_tc_cnt",   32'(bus.cnt),   32'd0);
    idle(2);

    // limit 0 periodic: tc on every tick
    cmd(OP_START, 0, 0, 1'b1);
    idle(5);
    cmd(OP_ABORT, 0, 0, 1'b0);

    // asynchronous reset mid-count, then full-range one-shot
    cmd(OP_START, 12, 1, 1'b1);
    idle(7);
    async_reset_mid_cycle();
    cmd(OP_START, 15, 0, 1'b0);
    idle(20);
    check("fullrange_state", 32'(bus.state), 32'd3);
    check("fullrange_cnt",   32'(bus.cnt),   32'd15);

    // randomized command traffic
    for (int i = 0; i < 1500; i++) begin
      v   = ($urandom_range(0, 3) == 0);
      op  = 2'($urandom_range(0, 3));
      if (op == OP_ABORT && $urandom_range(0, 2) != 0) op = OP_START;
      lim = ($urandom_range(0, 4) == 0) ? 15 : int'($urandom_range(0, 6));
      pre = $urandom_range(0, 3);
      per = 1'($urandom_range(0, 1));
      step(v, op, lim, pre, per);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/counter_sched.md
Name: counter_sched

Overview:
- Controller that sequences a free-running-style up-counter datapath as a programmable timer.
- Accepts commands over a valid/ready handshake: start, pause, resume, abort.
- Divides the clock by a programmable prescale and counts 0..limit.
- Raises a terminal-count pulse and optionally auto-reloads (periodic mode).
- Sits between a host/sequencer and the counter-based timing logic; drives the count value directly.

Parameters:
CNT_W, 4, counter width in bits.
PRE_W, 8, prescale register width in bits.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_op  input  2  0=START, 1=PAUSE, 2=RESUME, 3=ABORT
cmd_limit  input  CNT_W  terminal count, sampled on START
cmd_pre  input  PRE_W  prescale N (tick every N+1 clocks), sampled on START
cmd_periodic  input  1  1=auto-reload on terminal count, sampled on START
cnt  output  CNT_W  current count
state  output  2  0=IDLE, 1=RUN, 2=PAUSE, 3=DONE
tc  output  1  one-cycle pulse on reaching limit
cmd_err  output  1  one-cycle pulse: command illegal in current state (accepted, ignored)

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, cnt=0, tc=0, cmd_err=0, cmd_ready=1.
  - Prescaler, limit, periodic and pre registers cleared.
- Handshake:
  - A command is accepted on any edge with cmd_valid=1 and cmd_ready=1.
  - cmd_ready is 0 on the cycle after an acceptance, then 1 again. Max one command per 2 cycles.
  - cmd_op and cmd_* inputs are sampled only at acceptance.
- Legal transitions (take effect on the accepting edge):
  - START from IDLE or DONE -> RUN:
    - latch limit/pre/periodic.
    - cnt=0, prescaler=0.
  - START in RUN or PAUSE -> cmd_err, no change.
  - PAUSE from RUN -> PAUSE: cnt and prescaler frozen.
  - RESUME from PAUSE -> RUN: continues from the frozen cnt and prescaler.
  - ABORT from any state -> IDLE: cnt=0, prescaler=0, tc=0.
  - PAUSE outside RUN, or RESUME outside PAUSE -> cmd_err pulse, no state change.
- Tick generation in RUN:
  - prescaler counts 0..pre.
  - tick asserts on the cycle where prescaler==pre; prescaler then wraps to 0.
  - pre=0 gives a tick every clock.
- Counting on tick:
  - If cnt!=limit: cnt <= cnt+1.
  - If cnt==limit:
    - tc pulses for one cycle (registered, high the cycle after the edge).
    - periodic=1: cnt <= 0, stay in RUN.
    - periodic=0: state <= DONE, cnt holds limit.
- limit=0:
  - the first tick fires tc.
  - periodic mode: tc on every tick, cnt stays 0.
- Width: cnt never exceeds limit; limit=2^CNT_W-1 counts the full range, with no wrap beyond it.
- Simultaneous events:
  - Command accepted on the same edge as a tick: the command wins.
    - PAUSE freezes the pre-tick values; that tick is lost.
    - ABORT clears.
    - No tc that cycle.
- DONE: cnt holds limit; tc low; only START (restart) or ABORT are legal.
- Reset mid-operation: immediate return to reset values, regardless of state.
- Outputs cnt, state, tc, cmd_err, cmd_ready are all registered.

Test Plan:
1. Reset, then START limit=3 pre=0 periodic=0 -> cnt 0,1,2,3 on successive clocks; tc pulse when cnt reaches 3; state=DONE; cnt holds 3.
2. START limit=2 pre=2 periodic=1 -> cnt increments every 3 clocks; sequence 0,1,2,0,1,2; tc each time cnt reaches 2; state stays RUN.
3. RUN at cnt=5, PAUSE accepted, wait 10 clocks, RESUME -> cnt stays 5 while paused; resumes incrementing with prescaler phase preserved; cmd_ready low exactly one cycle after each accept.
4. START while in RUN -> cmd_err one-cycle pulse; cnt/state unaffected. RESUME while in IDLE -> cmd_err.
5. ABORT coincident with terminal tick (limit=1, pre=0) -> state=IDLE, cnt=0, no tc pulse.
6. Assert rst_n=0 asynchronously mid-count (between clock edges) -> cnt=0, state=IDLE immediately; after release, START limit=15 counts 0..15, then DONE with no wrap.
